ram_sp_sr_bw_init: RTL and testbench
====================================

# ram_sp_sr_bw_init

Single-port RAM with a bidirectional data bus, generalised from the asynchronous-read RAM generation. It adds registered (synchronous) reads with a read-valid strobe, per-byte write enables, and a parametrised data width, byte width and depth. It also runs a hardware clear sweep after reset that writes INIT_VALUE to every location before accepting accesses. It sits on a shared tri-state data bus behind a bus master that honours `ready` and `rvalid`.

## Interface
- DATA_WIDTH, 32, data bus width; must be an integer multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, width of one byte lane
- ADDR_WIDTH, 8, address width
- RAM_DEPTH, (1 << ADDR_WIDTH), number of words; must be ≤ 2^ADDR_WIDTH
- INIT_VALUE, 0, DATA_WIDTH-wide value written to every word by the clear sweep
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset; asynchronous and active-high
- address  input  ADDR_WIDTH  word address
- data  inout  DATA_WIDTH  write data in; read data out when driven
- be  input  DATA_WIDTH/BYTE_WIDTH  byte-lane write enables; bit i covers data[i*BYTE_WIDTH +: BYTE_WIDTH]
- cs  input  1  chip select
- we  input  1  1 = write, 0 = read
- oe  input  1  output enable for the tri-state driver
- ready  output  1  1 = clear sweep done, accesses accepted
- rvalid  output  1  1 = data_out holds the result of the read accepted on the previous edge

## Operation
- States: ST_INIT and ST_IDLE. While rst = 1 the block is held in ST_INIT.
- Reset values: ready = 0, rvalid = 0, data_out = 0, init counter = 0, data bus = Z.
- Clear sweep (ST_INIT):
  - Each edge writes INIT_VALUE to mem[init_cnt] and increments init_cnt.
  - The edge that writes RAM_DEPTH-1 also sets ready = 1 and moves to ST_IDLE.
  - cs, we, be and address are ignored in ST_INIT; rvalid stays 0.
- Write (ST_IDLE, cs = 1, we = 1):
  - For each lane i with be[i] = 1, that lane of mem[address] takes the corresponding bus lane.
  - Other lanes keep their value. be = 0 writes nothing.
- Read (ST_IDLE, cs = 1, we = 0):
  - data_out <= mem[address] and rvalid <= 1 on the same edge.
  - rvalid is 0 after any edge without an accepted read.
  - data_out holds its last value between reads.
- Bus driver (combinational): data = (rvalid && oe && !we) ? data_out : Z. The block never drives the bus in ST_INIT.
- Out-of-range address (address ≥ RAM_DEPTH, non-power-of-two depth only):
  - Writes are dropped.
  - Reads return all zeros, with rvalid still asserted.
- The write condition does not depend on oe.

## Timing
- Read latency is 1 clock: read accepted on edge N, data valid and driven (if oe = 1) from just after edge N until edge N+1.
- Back-to-back reads give rvalid high continuously, with one new word per cycle.
- Write then read of the same address on the next edge returns the new data. There is no forwarding hazard because the port is single.
- Clear duration: ready rises on the RAM_DEPTH-th rising edge after rst deasserts.
- Reset mid-sweep or mid-read:
  - ready and rvalid drop immediately (asynchronously) and the bus goes Z.
  - On release, the sweep restarts from address 0.
  - Words not yet re-cleared keep stale content until the sweep reaches them.
- Init counter width is ADDR_WIDTH+1 bits. The terminal compare is against RAM_DEPTH-1, so there is no wrap.

## Structure
- Shared package ram_pkg:
  - State enum (ST_INIT, ST_IDLE).
  - Derived localparam NUM_BYTES = DATA_WIDTH / BYTE_WIDTH.
  - Elaboration-time check that DATA_WIDTH % BYTE_WIDTH == 0 and RAM_DEPTH ≤ 2^ADDR_WIDTH.
- Single module, with no sub-module. The byte-lane write is a generate loop over NUM_BYTES.

## Test plan
All scenarios use DATA_WIDTH = 32, ADDR_WIDTH = 4, RAM_DEPTH = 16, INIT_VALUE = 32'hA5A5A5A5.
- Reset release, no access:
  - ready = 0 for 15 edges and 1 at edge 16.
  - Reading address 7 then returns A5A5A5A5 with rvalid one cycle later and the bus driven only while oe = 1.
- Byte-enable write:
  - Write 32'h11223344 to address 3 with be = 4'b0101, then read address 3.
  - Required response: 32'hA522A544.
- Back-to-back reads:
  - Read addresses 1, 2, 3 on consecutive edges after writing 1, 2, 3 into them.
  - Required response: rvalid high for 3 cycles; bus shows 1, 2, 3 in order; bus Z the cycle after.
- Access during INIT:
  - cs = 1, we = 1, be = 4'hF, data = 0 at address 0 during the sweep.
  - Required response: write ignored, address 0 reads A5A5A5A5 after ready; bus never driven.
- Reset mid-read:
  - Assert rst between edges while rvalid = 1.
  - Required response: rvalid, ready and bus drop at once; after release the sweep repeats 16 edges and previously written words read A5A5A5A5.
- Bus contention guard:
  - Read accepted, then we = 1 asserted in the rvalid cycle with oe = 1.
  - Required response: bus not driven by the RAM; the write completes.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and elaboration helpers for the single-port RAM.
// Holds the controller state encoding and the byte-lane geometry.
package ram_pkg;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    function automatic int num_bytes(input int dw, input int bw);
        return dw / bw;
    endfunction

    function automatic bit cfg_ok(
        input int dw,
        input int bw,
        input int aw,
        input int depth
    );
        return (bw > 0) && (dw % bw == 0) &&
               (depth >= 1) && (depth <= (1 << aw));
    endfunction

endpackage

// File: rtl/ram_sp_sr_bw_init.sv
// Single-port RAM: registered reads, byte-lane writes, tri-state bus,
// and a post-reset sweep that loads INIT_VALUE into every word.
module ram_sp_sr_bw_init
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = (1 << ADDR_WIDTH),
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            address,
    inout  wire  [DATA_WIDTH-1:0]            data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic                             cs,
    input  logic                             we,
    input  logic                             oe,
    output logic                             ready,
    output logic                             rvalid
);

    localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH =
        (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST =
        (ADDR_WIDTH+1)'(RAM_DEPTH - 1);

    if (!cfg_ok(DATA_WIDTH, BYTE_WIDTH, ADDR_WIDTH, RAM_DEPTH)) begin : g_cfg_err
        $error("ram_sp_sr_bw_init: bad width/depth configuration");
    end

    state_t state, state_nxt;

    logic [ADDR_WIDTH:0]   init_cnt;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_BYTES-1:0]  lane_we;
    logic                  in_range;
    logic                  sweep;
    logic                  sweep_done;
    logic                  acc_wr;
    logic                  acc_rd;

    assign in_range   = {1'b0, address} < DEPTH;
    assign sweep      = (state == ST_INIT) && !rst;
    assign sweep_done = (init_cnt == LAST);
    assign acc_wr     = (state == ST_IDLE) && cs && we && in_range;
    assign acc_rd     = (state == ST_IDLE) && cs && !we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_INIT: if (sweep_done) state_nxt = ST_IDLE;
            ST_IDLE: state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT;
        endcase
    end

    // The sweep owns the write port until ready; bus writes only after.
    always_comb begin
        wr_addr = init_cnt[ADDR_WIDTH-1:0];
        wr_word = INIT_VALUE;
        lane_we = '0;
        if (sweep) begin
            lane_we = '1;
        end else if (acc_wr) begin
            wr_addr = address;
            wr_word = data;
            lane_we = be;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt <= '0;
            ready    <= 1'b0;
            rvalid   <= 1'b0;
            data_out <= '0;
        end else begin
            rvalid <= acc_rd;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (sweep_done) ready <= 1'b1;
            end
            if (acc_rd) data_out <= in_range ? rd_word : '0;
        end
    end

    for (genvar b = 0; b < NUM_BYTES; b++) begin : g_lane
        logic [BYTE_WIDTH-1:0] mem [RAM_DEPTH];

        always_ff @(posedge clk) begin
            if (lane_we[b]) begin
                mem[wr_addr] <= wr_word[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end

        assign rd_word[b*BYTE_WIDTH +: BYTE_WIDTH] = mem[address];
    end

    assign data = (rvalid && oe && !we) ? data_out : 'z;

endmodule

// File: tb/tb_ram_sp_sr_bw_init.sv
// Directed bench for ram_sp_sr_bw_init with a reference model
// compared every cycle plus literal expectations per scenario.
module tb_ram_sp_sr_bw_init;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam logic [31:0] INIT = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  address = '0;
    logic [3:0]  be = '0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic        oe = 1'b0;
    logic        ready;
    logic        rvalid;
    logic [31:0] tb_drv = '0;
    logic        tb_en = 1'b0;
    wire  [31:0] data;

    int checks = 0;
    int errors = 0;

    assign data = tb_en ? tb_drv : 'z;

    ram_sp_sr_bw_init #(
        .DATA_WIDTH(DW),
        .BYTE_WIDTH(8),
        .ADDR_WIDTH(AW),
        .RAM_DEPTH(DEPTH),
        .INIT_VALUE(INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .address(address),
        .data(data),
        .be(be),
        .cs(cs),
        .we(we),
        .oe(oe),
        .ready(ready),
        .rvalid(rvalid)
    );

    always #5 clk = ~clk;

    // Reference model: words as plain integers, sweep as a position.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_dout = '0;
    logic        m_ready = 1'b0;
    logic        m_rvalid = 1'b0;
    int          m_pos = 0;

    function automatic logic [31:0] merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  lanes
    );
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++)
            if (lanes[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready  <= 1'b0;
            m_rvalid <= 1'b0;
            m_dout   <= '0;
            m_pos    <= 0;
        end else if (!m_ready) begin
            m_mem[m_pos] <= INIT;
            m_pos        <= m_pos + 1;
            m_rvalid     <= 1'b0;
            if (m_pos == DEPTH - 1) m_ready <= 1'b1;
        end else begin
            m_rvalid <= cs && !we;
            if (cs && !we) m_dout <= m_mem[address];
            if (cs && we)
                m_mem[address] <= merge(m_mem[address], tb_drv, be);
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Undriven bus: accept Z or a resolved zero.
    task automatic chk_z(input string name, input logic [31:0] got);
        checks++;
        if (got !== 32'hzzzzzzzz && got !== 32'h0) begin
            errors++;
            $display("FAIL %s got=%h want=Z t=%0t", name, got, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_ready", {31'b0, ready}, {31'b0, m_ready});
        chk("model_rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
        if (tb_en)
            chk("model_bus_tb", data, tb_drv);
        else if (m_rvalid && oe && !we)
            chk("model_bus", data, m_dout);
        else
            chk_z("model_bus_z", data);
    end

    task automatic idle();
        cs = 0; we = 0; oe = 0; be = '0; tb_en = 0;
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            chk(tag, {31'b0, ready}, (i == 16) ? 32'd1 : 32'd0);
            #1;
            if (i == 8) begin
                tb_en = 0; we = 0; oe = 1; cs = 1; address = 4'd7;
            end
        end
        idle();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] lanes);
        address = a; tb_drv = d; be = lanes;
        tb_en = 1; cs = 1; we = 1; oe = 0;
        @(posedge clk); #2;
        idle();
    endtask

    task automatic rd(input string name, input logic [3:0] a,
                      input logic [31:0] exp, input logic en);
        address = a; cs = 1; we = 0; oe = en; tb_en = 0;
        @(posedge clk); #1;
        chk({name, "_rvalid"}, {31'b0, rvalid}, 32'd1);
        if (en) chk(name, data, exp);
        else chk_z({name, "_oe0"}, data);
        #1;
        idle();
    endtask

    initial begin
        // Access attempts during the sweep: write then read of addr 0/7.
        address = 4'd0; tb_drv = 32'h0; be = 4'hF;
        cs = 1; we = 1; tb_en = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        #1;
        rst = 0;
        sweep_check("sweep1_ready");

        rd("rd7", 4'd7, 32'hA5A5A5A5, 1'b1);
        rd("rd7", 4'd7, 32'hA5A5A5A5, 1'b0);
        rd("rd0_after_init", 4'd0, 32'hA5A5A5A5, 1'b1);

        wr(4'd3, 32'h11223344, 4'b0101);
        rd("be_merge", 4'd3, 32'hA522A544, 1'b1);
        wr(4'd4, 32'hFFFFFFFF, 4'b0000);
        rd("be_none", 4'd4, 32'hA5A5A5A5, 1'b1);

        wr(4'd1, 32'd1, 4'hF);
        wr(4'd2, 32'd2, 4'hF);
        wr(4'd3, 32'd3, 4'hF);
        cs = 1; we = 0; oe = 1;
        for (int i = 1; i <= 3; i++) begin
            address = 4'(i);
            @(posedge clk); #1;
            chk("b2b_data", data, 32'(i));
            chk("b2b_rvalid", {31'b0, rvalid}, 32'd1);
            #1;
        end
        cs = 0;
        @(posedge clk); #1;
        chk("b2b_end_rvalid", {31'b0, rvalid}, 32'd0);
        chk_z("b2b_end_bus", data);
        #1;
        idle();

        wr(4'd5, 32'hDEADBEEF, 4'hF);
        rd("pre_rst", 4'd5, 32'hDEADBEEF, 1'b1);
        cs = 1; we = 0; oe = 1; address = 4'd5;
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("midrd_ready", {31'b0, ready}, 32'd0);
        chk("midrd_rvalid", {31'b0, rvalid}, 32'd0);
        chk_z("midrd_bus", data);
        idle();
        @(posedge clk); #2;
        rst = 0;
        sweep_check("sweep2_ready");
        rd("reclear5", 4'd5, 32'hA5A5A5A5, 1'b1);
        rd("reclear3", 4'd3, 32'hA5A5A5A5, 1'b1);

        wr(4'd9, 32'h12345678, 4'hF);
        address = 4'd9; cs = 1; we = 0; oe = 1;
        @(posedge clk); #1;
        chk("guard_rd", data, 32'h12345678);
        #1;
        we = 1; be = 4'hF; tb_drv = 32'hCAFEF00D; tb_en = 1;
        #1;
        chk("guard_bus", data, 32'hCAFEF00D);
        @(posedge clk); #2;
        idle();
        rd("guard_wr", 4'd9, 32'hCAFEF00D, 1'b1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
